// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-ported memory bus between the
// instruction-fetch requester (I) and the load/store requester (D).
// Each access runs IDLE -> BUS -> RESP. Data has fixed priority, but I is
// forced through after STARVE_LIMIT consecutive D grants. A bus phase that
// sees no iMemAck within TIMEOUT cycles is aborted with a bus-error pulse.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReqI,
  input  logic [31:0] iAddrI,
  output logic [31:0] oRDataI,
  output logic        oAckI,
  input  logic        iReqD,
  input  logic        iWED,
  input  logic [3:0]  iBED,
  input  logic [31:0] iAddrD,
  input  logic [31:0] iWDataD,
  output logic [31:0] oRDataD,
  output logic        oAckD,
  output logic        oMemReq,
  output logic        oMemWE,
  output logic [3:0]  oMemBE,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  input  logic [31:0] iMemRData,
  input  logic        iMemAck,
  output logic        oBusErr,
  output logic [1:0]  oGrant
);

  localparam logic [3:0] LP_STARVE  = 4'(STARVE_LIMIT);
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_starve;
  logic [7:0]  r_tcnt;
  logic        r_memReq;
  logic        r_memWE;
  logic [3:0]  r_memBE;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWData;
  logic [1:0]  r_grant;
  logic        r_ackI;
  logic        r_ackD;
  logic [31:0] r_rdataI;
  logic [31:0] r_rdataD;
  logic        r_busErr;

  logic        w_grantD;
  logic        w_grantI;
  logic [7:0]  w_tnext;
  logic [31:0] w_respData;

  // D wins arbitration unless I is waiting and has already been passed over
  // STARVE_LIMIT times in a row; writes and aborted reads return zero data.
  always_comb begin
    w_grantD   = iReqD && !(iReqI && (r_starve == LP_STARVE));
    w_grantI   = !w_grantD && iReqI;
    w_tnext    = r_tcnt + 8'd1;
    w_respData = (iMemAck && !r_memWE) ? iMemRData : 32'h0;
  end

  // Single access sequencer: grants in IDLE, waits for the memory in BUS,
  // and pulses the owner's ack (plus any bus error) for one cycle in RESP.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state    <= IDLE;
      r_starve   <= 4'd0;
      r_tcnt     <= 8'd0;
      r_memReq   <= 1'b0;
      r_memWE    <= 1'b0;
      r_memBE    <= 4'h0;
      r_memAddr  <= 32'h0;
      r_memWData <= 32'h0;
      r_grant    <= GRANT_NONE;
      r_ackI     <= 1'b0;
      r_ackD     <= 1'b0;
      r_rdataI   <= 32'h0;
      r_rdataD   <= 32'h0;
      r_busErr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tcnt <= 8'd0;
          if (w_grantD) begin
            r_state    <= BUS;
            r_memReq   <= 1'b1;
            r_memWE    <= iWED;
            r_memBE    <= iBED;
            r_memAddr  <= iAddrD;
            r_memWData <= iWDataD;
            r_grant    <= GRANT_D;
            if (!iReqI) begin
              r_starve <= 4'd0;
            end else if (r_starve != LP_STARVE) begin
              r_starve <= r_starve + 4'd1;
            end
          end else if (w_grantI) begin
            r_state    <= BUS;
            r_memReq   <= 1'b1;
            r_memWE    <= 1'b0;
            r_memBE    <= 4'hF;
            r_memAddr  <= iAddrI;
            r_memWData <= 32'h0;
            r_grant    <= GRANT_I;
            r_starve   <= 4'd0;
          end
        end

        BUS: begin
          r_tcnt <= w_tnext;
          if (iMemAck || (w_tnext == LP_TIMEOUT)) begin
            r_state  <= RESP;
            r_memReq <= 1'b0;
            r_busErr <= !iMemAck;
            if (r_grant == GRANT_I) begin
              r_ackI   <= 1'b1;
              r_rdataI <= w_respData;
            end else begin
              r_ackD   <= 1'b1;
              r_rdataD <= w_respData;
            end
          end
        end

        RESP: begin
          r_state    <= IDLE;
          r_tcnt     <= 8'd0;
          r_memWE    <= 1'b0;
          r_memBE    <= 4'h0;
          r_memAddr  <= 32'h0;
          r_memWData <= 32'h0;
          r_grant    <= GRANT_NONE;
          r_ackI     <= 1'b0;
          r_ackD     <= 1'b0;
          r_rdataI   <= 32'h0;
          r_rdataD   <= 32'h0;
          r_busErr   <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign oMemReq   = r_memReq;
  assign oMemWE    = r_memWE;
  assign oMemBE    = r_memBE;
  assign oMemAddr  = r_memAddr;
  assign oMemWData = r_memWData;
  assign oGrant    = r_grant;
  assign oAckI     = r_ackI;
  assign oAckD     = r_ackD;
  assign oRDataI   = r_rdataI;
  assign oRDataD   = r_rdataD;
  assign oBusErr   = r_busErr;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios for the shared memory-bus arbiter
// with STARVE_LIMIT=4 and TIMEOUT=8; expected values are hand-computed.
module tb_mem_bus_arbiter;

  logic        iCLK;
  logic        iRST;
  logic        iReqI;
  logic [31:0] iAddrI;
  logic [31:0] oRDataI;
  logic        oAckI;
  logic        iReqD;
  logic        iWED;
  logic [3:0]  iBED;
  logic [31:0] iAddrD;
  logic [31:0] iWDataD;
  logic [31:0] oRDataD;
  logic        oAckD;
  logic        oMemReq;
  logic        oMemWE;
  logic [3:0]  oMemBE;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWData;
  logic [31:0] iMemRData;
  logic        iMemAck;
  logic        oBusErr;
  logic [1:0]  oGrant;

  int compared;
  int mismatched;

  mem_bus_arbiter #(
    .STARVE_LIMIT(4),
    .TIMEOUT(8)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iReqI(iReqI),
    .iAddrI(iAddrI),
    .oRDataI(oRDataI),
    .oAckI(oAckI),
    .iReqD(iReqD),
    .iWED(iWED),
    .iBED(iBED),
    .iAddrD(iAddrD),
    .iWDataD(iWDataD),
    .oRDataD(oRDataD),
    .oAckD(oAckD),
    .oMemReq(oMemReq),
    .oMemWE(oMemWE),
    .oMemBE(oMemBE),
    .oMemAddr(oMemAddr),
    .oMemWData(oMemWData),
    .iMemRData(iMemRData),
    .iMemAck(iMemAck),
    .oBusErr(oBusErr),
    .oGrant(oGrant)
  );

  // 10 ns core clock
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  // advance one cycle and settle just after the rising edge
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset();
    iRST = 1'b0;
    iReqI = 1'b0; iAddrI = 32'h0;
    iReqD = 1'b0; iWED = 1'b0; iBED = 4'h0; iAddrD = 32'h0; iWDataD = 32'h0;
    iMemRData = 32'h0; iMemAck = 1'b0;
    tick();
    tick();
    compared++;
    if ({oMemReq, oMemWE, oMemBE, oMemAddr, oMemWData, oGrant, oAckI, oAckD, oRDataI, oRDataD, oBusErr} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got grant=%b memReq=%b ackI=%b ackD=%b err=%b addr=%h expected all zero",
               oGrant, oMemReq, oAckI, oAckD, oBusErr, oMemAddr);
    end
    iRST = 1'b1;
    tick();
    // memory ack while idle must be ignored
    iMemAck = 1'b1; iMemRData = 32'h12345678;
    tick();
    iMemAck = 1'b0;
    tick();
    compared++;
    if ({oAckI, oAckD, oGrant, oMemReq} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_ack_ignored: got ackI=%b ackD=%b grant=%b memReq=%b expected all zero",
               oAckI, oAckD, oGrant, oMemReq);
    end
  endtask

  task automatic test_i_read();
    iReqI = 1'b1; iAddrI = 32'h00400000;
    tick();
    compared++;
    if ({oMemReq, oMemWE, oMemBE, oMemAddr, oGrant} !== {1'b1, 1'b0, 4'hF, 32'h00400000, 2'b01}) begin
      mismatched++;
      $display("[TB] FAIL i_read_bus: got req=%b we=%b be=%h addr=%h grant=%b expected 1 0 f 00400000 01",
               oMemReq, oMemWE, oMemBE, oMemAddr, oGrant);
    end
    iMemAck = 1'b1; iMemRData = 32'h00000013;
    tick();
    iMemAck = 1'b0; iMemRData = 32'h0; iReqI = 1'b0;
    compared++;
    if ({oAckI, oRDataI, oAckD, oMemReq, oBusErr} !== {1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL i_read_resp: got ackI=%b data=%h ackD=%b req=%b err=%b expected 1 00000013 0 0 0",
               oAckI, oRDataI, oAckD, oMemReq, oBusErr);
    end
    tick();
    compared++;
    if ({oAckI, oRDataI, oGrant, oMemAddr, oMemBE} !== '0) begin
      mismatched++;
      $display("[TB] FAIL i_read_idle: got ackI=%b data=%h grant=%b addr=%h be=%h expected all zero",
               oAckI, oRDataI, oGrant, oMemAddr, oMemBE);
    end
  endtask

  task automatic test_d_write();
    iReqD = 1'b1; iWED = 1'b1; iBED = 4'b0011; iAddrD = 32'h10010000; iWDataD = 32'hDEADBEEF;
    tick();
    compared++;
    if ({oMemReq, oMemWE, oMemBE, oMemAddr, oMemWData, oGrant} !==
        {1'b1, 1'b1, 4'b0011, 32'h10010000, 32'hDEADBEEF, 2'b10}) begin
      mismatched++;
      $display("[TB] FAIL d_write_bus: got req=%b we=%b be=%b addr=%h wdata=%h grant=%b expected 1 1 0011 10010000 deadbeef 10",
               oMemReq, oMemWE, oMemBE, oMemAddr, oMemWData, oGrant);
    end
    tick();
    tick();
    compared++;
    if ({oMemReq, oAckD, oMemWData} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      mismatched++;
      $display("[TB] FAIL d_write_wait: got req=%b ackD=%b wdata=%h expected 1 0 deadbeef",
               oMemReq, oAckD, oMemWData);
    end
    iMemAck = 1'b1; iMemRData = 32'h55555555;
    tick();
    iMemAck = 1'b0; iMemRData = 32'h0; iReqD = 1'b0; iWED = 1'b0;
    compared++;
    if ({oAckD, oRDataD, oAckI, oBusErr} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL d_write_resp: got ackD=%b data=%h ackI=%b err=%b expected 1 00000000 0 0",
               oAckD, oRDataD, oAckI, oBusErr);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [1:0] expGrant [6];
    expGrant[0] = 2'b10; expGrant[1] = 2'b10; expGrant[2] = 2'b10;
    expGrant[3] = 2'b10; expGrant[4] = 2'b01; expGrant[5] = 2'b10;
    iReqI = 1'b1; iAddrI = 32'h00400100;
    iReqD = 1'b1; iWED = 1'b0; iBED = 4'hF; iAddrD = 32'h10010040;
    for (int t = 0; t < 6; t++) begin
      tick();
      compared++;
      if (oGrant !== expGrant[t]) begin
        mismatched++;
        $display("[TB] FAIL starve_grant[%0d]: got %b expected %b", t, oGrant, expGrant[t]);
      end
      iMemAck = 1'b1; iMemRData = 32'hA0000000 + 32'(t);
      tick();
      iMemAck = 1'b0;
      if (t == 5) begin
        iReqI = 1'b0; iReqD = 1'b0;
      end
      compared++;
      if (expGrant[t] == 2'b01) begin
        if ({oAckI, oAckD, oRDataI} !== {1'b1, 1'b0, 32'hA0000000 + 32'(t)}) begin
          mismatched++;
          $display("[TB] FAIL starve_ack[%0d]: got ackI=%b ackD=%b dataI=%h expected 1 0 %h",
                   t, oAckI, oAckD, oRDataI, 32'hA0000000 + 32'(t));
        end
      end else begin
        if ({oAckI, oAckD, oRDataD} !== {1'b0, 1'b1, 32'hA0000000 + 32'(t)}) begin
          mismatched++;
          $display("[TB] FAIL starve_ack[%0d]: got ackI=%b ackD=%b dataD=%h expected 0 1 %h",
                   t, oAckI, oAckD, oRDataD, 32'hA0000000 + 32'(t));
        end
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    int reqCycles;
    reqCycles = 0;
    iReqD = 1'b1; iWED = 1'b0; iBED = 4'hF; iAddrD = 32'h10010080;
    iMemRData = 32'h77777777;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (oMemReq === 1'b1) reqCycles++;
    end
    compared++;
    if (reqCycles != 8) begin
      mismatched++;
      $display("[TB] FAIL timeout_req_cycles: got %0d expected 8", reqCycles);
    end
    tick();
    iReqD = 1'b0;
    compared++;
    if ({oAckD, oBusErr, oRDataD, oMemReq} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL timeout_resp: got ackD=%b err=%b data=%h req=%b expected 1 1 00000000 0",
               oAckD, oBusErr, oRDataD, oMemReq);
    end
    tick();
    compared++;
    if ({oBusErr, oAckD, oGrant} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_after: got err=%b ackD=%b grant=%b expected 0 0 00",
               oBusErr, oAckD, oGrant);
    end
  endtask

  task automatic test_ack_at_timeout();
    iReqD = 1'b1; iWED = 1'b0; iBED = 4'hF; iAddrD = 32'h100100C0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 8) begin
        iMemAck = 1'b1; iMemRData = 32'hCAFEF00D;
      end
    end
    tick();
    iMemAck = 1'b0; iMemRData = 32'h0; iReqD = 1'b0;
    compared++;
    if ({oAckD, oBusErr, oRDataD} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      mismatched++;
      $display("[TB] FAIL ack_at_timeout: got ackD=%b err=%b data=%h expected 1 0 cafef00d",
               oAckD, oBusErr, oRDataD);
    end
    tick();
  endtask

  task automatic test_reset_mid_bus();
    iReqI = 1'b1; iAddrI = 32'h00400200;
    tick();
    tick();
    #2;
    iRST = 1'b0;
    #1;
    compared++;
    if ({oMemReq, oMemAddr, oMemBE, oGrant, oAckI, oAckD, oBusErr} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_bus: got req=%b addr=%h grant=%b ackI=%b expected all zero",
               oMemReq, oMemAddr, oGrant, oAckI);
    end
    iReqI = 1'b0;
    iMemAck = 1'b1; iMemRData = 32'h99999999;
    tick();
    iMemAck = 1'b0;
    compared++;
    if ({oAckI, oRDataI} !== 33'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_no_ack: got ackI=%b data=%h expected 0 00000000", oAckI, oRDataI);
    end
    iRST = 1'b1;
    iReqD = 1'b1; iWED = 1'b0; iBED = 4'hF; iAddrD = 32'h10010100;
    tick();
    compared++;
    if ({oGrant, oMemReq, oMemAddr} !== {2'b10, 1'b1, 32'h10010100}) begin
      mismatched++;
      $display("[TB] FAIL post_reset_grant: got grant=%b req=%b addr=%h expected 10 1 10010100",
               oGrant, oMemReq, oMemAddr);
    end
    iMemAck = 1'b1; iMemRData = 32'h0BADF00D;
    tick();
    iMemAck = 1'b0; iReqD = 1'b0;
    compared++;
    if ({oAckD, oRDataD} !== {1'b1, 32'h0BADF00D}) begin
      mismatched++;
      $display("[TB] FAIL post_reset_resp: got ackD=%b data=%h expected 1 0badf00d", oAckD, oRDataD);
    end
    tick();
  endtask

  // run every scenario in order, then report
  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_i_read();
    test_d_write();
    test_starvation();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported memory bus between the instruction-fetch requester (I) and the load/store requester (D).
- Sequences each access as grant, bus phase, response.
- Used where the fetch path and data path must target one physical memory instead of separate code and data memories.
- Sits between the datapath bus outputs and the memory interface. Provides fixed data priority, I-starvation protection and a bus timeout.

Parameters:
STARVE_LIMIT, 4, max consecutive D grants while I is requesting before I is forced through (1..15)
TIMEOUT, 255, bus-phase cycles without iMemAck before abort (1..255)

Ports:
iCLK  in  1  core clock
iRST  in  1  asynchronous, active-low reset
iReqI  in  1  fetch request; held high until oAckI
iAddrI  in  32  fetch address
oRDataI  out  32  fetch data; valid only while oAckI=1
oAckI  out  1  one-cycle completion pulse for I
iReqD  in  1  data request; held high until oAckD
iWED  in  1  1=write, 0=read
iBED  in  4  byte enables
iAddrD  in  32  data address
iWDataD  in  32  write data
oRDataD  out  32  read data; valid only while oAckD=1
oAckD  out  1  one-cycle completion pulse for D
oMemReq  out  1  bus request to memory
oMemWE  out  1  bus write enable
oMemBE  out  4  bus byte enables
oMemAddr  out  32  bus address
oMemWData  out  32  bus write data
iMemRData  in  32  memory read data; valid with iMemAck
iMemAck  in  1  memory completion, one cycle
oBusErr  out  1  one-cycle pulse on timeout abort
oGrant  out  2  current owner: 00 none, 01 I, 10 D

Behaviour:
- Reset (iRST=0, asynchronous):
  - state IDLE.
  - All outputs 0.
  - Starve and timeout counters 0.
  - An in-flight memory access is abandoned with no ack.
- States: IDLE, BUS, RESP.
- IDLE, choosing the owner:
  - If iReqD=1 and not (iReqI=1 and starve==STARVE_LIMIT), grant D.
  - Else if iReqI=1, grant I.
  - Else remain in IDLE.
- IDLE, on a grant:
  - Latch the owner's address, WE, BE and wdata into bus registers. I always uses WE=0, BE=4'b1111, wdata 0.
  - Go to BUS and set oGrant.
- Starve counter:
  - On a D grant with iReqI=1: increment, saturating at STARVE_LIMIT.
  - On an I grant: clear.
  - On a D grant with iReqI=0: clear.
- BUS:
  - oMemReq=1. Bus registers stay stable for the whole phase.
  - The timeout counter increments each cycle.
  - On iMemAck=1: capture iMemRData into the response register (write accesses capture 32'h0), go to RESP.
  - Else, when the counter reaches TIMEOUT: capture 32'h0, set the error flag, go to RESP. iMemAck arriving in the same cycle as the timeout wins; there is no error in that case.
- RESP:
  - oMemReq=0.
  - The owner's oAck pulses high for exactly this cycle, with oRData driven from the response register.
  - oBusErr=1 this cycle if the error flag is set.
  - Next state IDLE; oGrant returns to 00; timeout counter and error flag clear.
- Latency: minimum 3 cycles from request seen in IDLE to ack (IDLE, BUS with immediate iMemAck, RESP). Each additional memory wait cycle adds 1.
- Outside RESP:
  - oAckI and oAckD are 0.
  - oRDataI and oRDataD are 0.
- iMemAck outside BUS is ignored.
- Requesters drop their request in the cycle after ack, which is the IDLE cycle, so no spurious re-grant occurs. A request still high in that IDLE cycle is treated as a new transaction.
- Both requests arriving in the same IDLE cycle: D wins unless the starve counter is at the limit.
- Requests that change or drop during BUS or RESP are ignored. Behaviour is defined by the latched values.
- oMemWE, oMemBE, oMemAddr and oMemWData are held at their latched values in BUS. They are 0 in IDLE.

Test Plan:
- I-only read: iReqI=1, iAddrI=0x00400000; memory acks in first BUS cycle with 0x00000013 -> oMemReq high 1 cycle with oMemAddr=0x00400000, oMemBE=4'hF, oMemWE=0; oAckI=1 with oRDataI=0x00000013 on the 3rd cycle.
- D write: iReqD=1, iWED=1, iBED=4'b0011, iAddrD=0x10010000, iWDataD=0xDEADBEEF; ack after 2 wait cycles -> bus fields match; oAckD on cycle 5; oRDataD=0.
- Simultaneous requests: iReqI and iReqD held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,...; oGrant follows this order.
- Timeout: iReqD read, iMemAck never asserted, TIMEOUT=8 -> oMemReq high 8 cycles; then oAckD=1, oBusErr=1, oRDataD=0 for one cycle.
- Ack and timeout in the same cycle: iMemAck asserted exactly in the cycle the counter reaches TIMEOUT -> oBusErr=0 and the captured data is returned.
- Reset mid-BUS: iRST low during an I access -> all outputs 0 immediately with no ack; after release, a new iReqD is granted from IDLE.
